// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared definitions for the execute stage. This package holds
//                the 5-bit decoded opcodes and the bit positions of the status
//                flags inside the 4-bit flag word {Z,C,V,S}.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int OP_W = 5;

    // Arithmetic
    localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OP_W-1:0] OP_MOV = 5'b00010;
    localparam logic [OP_W-1:0] OP_AND = 5'b00100;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_XOR = 5'b00110;
    localparam logic [OP_W-1:0] OP_NOT = 5'b00111;
    // Immediate variants (operand B carries the immediate)
    localparam logic [OP_W-1:0] OP_ADI = 5'b01000;
    localparam logic [OP_W-1:0] OP_SBI = 5'b01001;
    localparam logic [OP_W-1:0] OP_MVI = 5'b01010;
    localparam logic [OP_W-1:0] OP_ANI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI = 5'b01101;
    localparam logic [OP_W-1:0] OP_XRI = 5'b01110;
    localparam logic [OP_W-1:0] OP_NTI = 5'b01111;
    // Memory, port and control transfer
    localparam logic [OP_W-1:0] OP_LD  = 5'b10100;
    localparam logic [OP_W-1:0] OP_ST  = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN  = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT = 5'b10111;
    localparam logic [OP_W-1:0] OP_JMP = 5'b11000;
    // Shift / rotate / increment / decrement
    localparam logic [OP_W-1:0] OP_LSL = 5'b11001;
    localparam logic [OP_W-1:0] OP_LSR = 5'b11010;
    localparam logic [OP_W-1:0] OP_ASR = 5'b11011;
    localparam logic [OP_W-1:0] OP_ROL = 5'b11100;
    localparam logic [OP_W-1:0] OP_ROR = 5'b11101;
    localparam logic [OP_W-1:0] OP_INC = 5'b11110;
    localparam logic [OP_W-1:0] OP_DEC = 5'b11111;

    // Flag word layout
    localparam int c_FLAG_W = 4;
    localparam int c_FLAG_Z = 3;
    localparam int c_FLAG_C = 2;
    localparam int c_FLAG_V = 1;
    localparam int c_FLAG_S = 0;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
//  Module      : exec_alu
//  Description : Combinational datapath of the execute stage. Produces the
//                result, its write enable, the {Z,C,V,S} flag word and the
//                flag write enable for one decoded opcode.
//  Ports       : a, b, data_in  - operands and input-port data
//                op             - decoded opcode
//                result/res_we  - result value and "load ans_ex" strobe
//                flags/flag_we  - flag word and "load flag_ex" strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [OP_W-1:0]     op,
    output logic [DATA_W-1:0]   result,
    output logic                res_we,
    output logic [c_FLAG_W-1:0] flags,
    output logic                flag_we
);

    localparam int SHW = $clog2(DATA_W);
    localparam logic [DATA_W:0] c_ONE = {{DATA_W{1'b0}}, 1'b1};

    logic [SHW-1:0]       w_amt;
    logic [DATA_W:0]      w_sum;
    logic [DATA_W:0]      w_dif;
    logic [DATA_W:0]      w_inc;
    logic [DATA_W:0]      w_dec;
    logic [DATA_W:0]      w_lsl;
    logic [DATA_W:0]      w_lsr;
    logic signed [DATA_W:0] w_asr;
    logic [DATA_W-1:0]    w_rol;
    logic [DATA_W-1:0]    w_ror;
    logic                 w_amt_nz;
    logic                 w_carry;
    logic                 w_ovf;

    assign w_amt    = b[SHW-1:0];
    assign w_amt_nz = (w_amt != '0);

    // One extra MSB holds carry-out (add) or borrow (subtract).
    assign w_sum = {1'b0, a} + {1'b0, b};
    assign w_dif = {1'b0, a} - {1'b0, b};
    assign w_inc = {1'b0, a} + c_ONE;
    assign w_dec = {1'b0, a} - c_ONE;

    // Left shift keeps the last bit out in the extra MSB; right shifts keep it
    // in an extra LSB. A zero shift amount leaves that extra bit at 0.
    assign w_lsl = {1'b0, a} << w_amt;
    assign w_lsr = {a, 1'b0} >> w_amt;
    assign w_asr = $signed({a, 1'b0}) >>> w_amt;

    // Rotates via a doubled operand; the bit last rotated out lands at R[0]
    // for ROL and at R[MSB] for ROR.
    assign w_rol = DATA_W'(({a, a} << w_amt) >> DATA_W);
    assign w_ror = DATA_W'({a, a} >> w_amt);

    always_comb begin
        result  = '0;
        res_we  = 1'b0;
        flag_we = 1'b0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op)
            OP_ADD, OP_ADI: begin
                result  = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
                w_ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_SUB, OP_SBI: begin
                result  = w_dif[DATA_W-1:0];
                w_carry = w_dif[DATA_W];
                w_ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (w_dif[DATA_W-1] != a[DATA_W-1]);
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_AND, OP_ANI: begin
                result  = a & b;
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_OR, OP_ORI: begin
                result  = a | b;
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_XOR, OP_XRI: begin
                result  = a ^ b;
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_NOT, OP_NTI: begin
                result  = ~a;
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_MOV, OP_MVI, OP_LD, OP_ST, OP_JMP: begin
                result  = b;
                res_we  = 1'b1;
            end
            OP_IN: begin
                result  = data_in;
                res_we  = 1'b1;
            end
            OP_LSL: begin
                result  = w_lsl[DATA_W-1:0];
                w_carry = w_lsl[DATA_W];
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_LSR: begin
                result  = w_lsr[DATA_W:1];
                w_carry = w_lsr[0];
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_ASR: begin
                result  = w_asr[DATA_W:1];
                w_carry = w_asr[0];
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_ROL: begin
                result  = w_rol;
                w_carry = w_amt_nz & w_rol[0];
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_ROR: begin
                result  = w_ror;
                w_carry = w_amt_nz & w_ror[DATA_W-1];
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_INC: begin
                result  = w_inc[DATA_W-1:0];
                w_carry = w_inc[DATA_W];
                w_ovf   = ~a[DATA_W-1] & w_inc[DATA_W-1];
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_DEC: begin
                result  = w_dec[DATA_W-1:0];
                w_carry = w_dec[DATA_W];
                w_ovf   = a[DATA_W-1] & ~w_dec[DATA_W-1];
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            default: begin
                // NOP, OUT and unassigned codes: nothing updated here.
            end
        endcase

        flags           = '0;
        flags[c_FLAG_Z] = (result == '0);
        flags[c_FLAG_C] = w_carry;
        flags[c_FLAG_V] = w_ovf;
        flags[c_FLAG_S] = result[DATA_W-1];
    end

endmodule : exec_alu
`default_nettype wire

// File: rtl/execution_block.sv
`default_nettype none
// ============================================================================
//  Module      : execution_block
//  Description : Execute stage of the 8-bit pipeline. One-cycle latency: the
//                operands are sampled on the rising clock edge and the result,
//                store data, output-port data and flags are registered.
//  Ports       : clk, reset (async, active-low)
//                A, B, data_in, op_dec          - stage inputs
//                ans_ex, DM_data, data_out      - registered data outputs
//                flag_ex                        - registered {Z,C,V,S}
//  Revision    : 1.0 - initial release
// ============================================================================
module execution_block
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [OP_W-1:0]     op_dec,
    output logic [DATA_W-1:0]   ans_ex,
    output logic [DATA_W-1:0]   DM_data,
    output logic [DATA_W-1:0]   data_out,
    output logic [c_FLAG_W-1:0] flag_ex
);

    logic [DATA_W-1:0]   w_result;
    logic                w_res_we;
    logic [c_FLAG_W-1:0] w_flags;
    logic                w_flag_we;

    logic [DATA_W-1:0]   r_ans;
    logic [DATA_W-1:0]   r_dm_data;
    logic [DATA_W-1:0]   r_data_out;
    logic [c_FLAG_W-1:0] r_flags;

    exec_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a       (A),
        .b       (B),
        .data_in (data_in),
        .op      (op_dec),
        .result  (w_result),
        .res_we  (w_res_we),
        .flags   (w_flags),
        .flag_we (w_flag_we)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ans      <= '0;
            r_dm_data  <= '0;
            r_data_out <= '0;
            r_flags    <= '0;
        end else begin
            if (w_res_we) begin
                r_ans <= w_result;
            end
            if (w_flag_we) begin
                r_flags <= w_flags;
            end
            if (op_dec == OP_ST) begin
                r_dm_data <= A;
            end
            if (op_dec == OP_OUT) begin
                r_data_out <= A;
            end
        end
    end

    assign ans_ex   = r_ans;
    assign DM_data  = r_dm_data;
    assign data_out = r_data_out;
    assign flag_ex  = r_flags;

endmodule : execution_block
`default_nettype wire

// File: tb/tb_execution_block.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execution_block
//  Description : Directed self-checking bench for execution_block with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execution_block;

    logic       clk;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] data_in;
    logic [4:0] op_dec;
    logic [7:0] ans_ex;
    logic [7:0] DM_data;
    logic [7:0] data_out;
    logic [3:0] flag_ex;

    int n_checks = 0;
    int n_pass   = 0;

    execution_block #(
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .data_in  (data_in),
        .op_dec   (op_dec),
        .ans_ex   (ans_ex),
        .DM_data  (DM_data),
        .data_out (data_out),
        .flag_ex  (flag_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] din);
        @(negedge clk);
        op_dec  = op;
        A       = a;
        B       = b;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic [7:0] r, input logic [3:0] f);
        check({tag, ".ans"},  {24'd0, ans_ex},  {24'd0, r});
        check({tag, ".flag"}, {28'd0, flag_ex}, {28'd0, f});
    endtask

    task automatic check_all(input string tag, input logic [7:0] r, input logic [7:0] dm,
                             input logic [7:0] dout, input logic [3:0] f);
        check_rf(tag, r, f);
        check({tag, ".dm"},  {24'd0, DM_data},  {24'd0, dm});
        check({tag, ".out"}, {24'd0, data_out}, {24'd0, dout});
    endtask

    initial begin
        reset   = 1'b0;
        A       = 8'd0;
        B       = 8'd0;
        data_in = 8'd0;
        op_dec  = 5'b10000;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 8'h00, 8'h00, 4'b0000);

        @(negedge clk);
        reset = 1'b1;

        // Arithmetic and logic, A=64 B=192
        apply(5'b00000, 8'd64, 8'd192, 8'd0); check_rf("add", 8'h00, 4'b1100);
        apply(5'b00001, 8'd64, 8'd192, 8'd0); check_rf("sub", 8'h80, 4'b0111);
        apply(5'b00100, 8'd64, 8'd192, 8'd0); check_rf("and", 8'h40, 4'b0000);
        apply(5'b00101, 8'd64, 8'd192, 8'd0); check_rf("or",  8'hC0, 4'b0001);
        apply(5'b00110, 8'd64, 8'd192, 8'd0); check_rf("xor", 8'h80, 4'b0001);
        apply(5'b00111, 8'd64, 8'd192, 8'd0); check_rf("not", 8'hBF, 4'b0001);
        apply(5'b00010, 8'd64, 8'd192, 8'd0); check_rf("mov", 8'hC0, 4'b0001);
        apply(5'b01000, 8'd127, 8'd1,  8'd0); check_rf("adi", 8'h80, 4'b0011);
        apply(5'b01001, 8'd5,  8'd5,   8'd0); check_rf("sbi", 8'h00, 4'b1000);

        // Memory and port
        apply(5'b10101, 8'd64, 8'd192, 8'd0);
        check_all("st", 8'hC0, 8'h40, 8'h00, 4'b1000);
        apply(5'b10111, 8'd64, 8'd17, 8'd0);
        check_all("out", 8'hC0, 8'h40, 8'h40, 4'b1000);
        apply(5'b10110, 8'd64, 8'd192, 8'd8); check_rf("in",  8'h08, 4'b1000);
        apply(5'b10100, 8'd9,  8'h33,  8'd0); check_rf("ld",  8'h33, 4'b1000);
        apply(5'b11000, 8'd9,  8'h5A,  8'd0); check_rf("jmp", 8'h5A, 4'b1000);

        // Shifts and rotates, A=192 B=1
        apply(5'b11001, 8'd192, 8'd1, 8'd0); check_rf("lsl", 8'h80, 4'b0101);
        apply(5'b11010, 8'd192, 8'd1, 8'd0); check_rf("lsr", 8'h60, 4'b0000);
        apply(5'b11011, 8'd192, 8'd1, 8'd0); check_rf("asr", 8'hE0, 4'b0001);
        apply(5'b11100, 8'd192, 8'd1, 8'd0); check_rf("rol", 8'h81, 4'b0101);
        apply(5'b11101, 8'd192, 8'd1, 8'd0); check_rf("ror", 8'h60, 4'b0000);
        apply(5'b11110, 8'd192, 8'd1, 8'd0); check_rf("inc", 8'hC1, 4'b0001);
        apply(5'b11111, 8'd192, 8'd1, 8'd0); check_rf("dec", 8'hBF, 4'b0001);
        // Shift-amount boundaries: zero amount, amount taken from B[2:0]
        apply(5'b11001, 8'd192, 8'd0,    8'd0); check_rf("lsl0", 8'hC0, 4'b0001);
        apply(5'b11001, 8'd192, 8'd3,    8'd0); check_rf("lsl3", 8'h00, 4'b1000);
        apply(5'b11101, 8'd192, 8'h0B,   8'd0); check_rf("ror3", 8'h18, 4'b0000);
        apply(5'b11011, 8'h81,  8'd2,    8'd0); check_rf("asr2", 8'hE0, 4'b0001);
        apply(5'b11110, 8'hFF,  8'd0,    8'd0); check_rf("incw", 8'h00, 4'b1100);
        apply(5'b11111, 8'h00,  8'd0,    8'd0); check_rf("decw", 8'hFF, 4'b0101);

        // NOPs after ADD: everything holds
        apply(5'b00000, 8'd64, 8'd192, 8'd0);
        check_all("add2", 8'h00, 8'h40, 8'h40, 4'b1100);
        apply(5'b10000, 8'd5, 8'd7, 8'd3); check_all("nop10000", 8'h00, 8'h40, 8'h40, 4'b1100);
        apply(5'b00011, 8'd5, 8'd7, 8'd3); check_all("nop00011", 8'h00, 8'h40, 8'h40, 4'b1100);
        apply(5'b10001, 8'd5, 8'd7, 8'd3); check_all("nop10001", 8'h00, 8'h40, 8'h40, 4'b1100);

        // Asynchronous reset mid-run with nonzero outputs
        apply(5'b00000, 8'd1, 8'd2, 8'd0);
        check_all("pre_rst", 8'h03, 8'h40, 8'h40, 4'b0000);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 8'h00, 8'h00, 4'b0000);
        @(posedge clk);
        #1;
        check_all("rst_hold", 8'h00, 8'h00, 8'h00, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_execution_block
`default_nettype wire
